idu_decq: RTL and testbench



---
 rtl/idu_decq.sv | 190 +++++++++++++++++++
 tb/tb_idu_decq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/idu_decq.sv
// idu_decq: decode queue between the IFU and idu1.
// Raw instructions are buffered in a DEPTH-entry FIFO. The FIFO head is
// decoded and captured into a registered idu0_out_t packet. The stage
// supports a synchronous pipeline flush.
// Optional feature: define IDU_DECQ_BYPASS_EN to let an instruction that
// arrives at an empty queue load straight into the output register.

package idu_decq_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSTR_LEN = 32;

  // Decoded packet handed to idu1.
  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      instr_tag;
    logic                 legal;
    logic                 alu;
    logic                 pc;      // auipc: operand is the PC
    logic                 shift;
    logic                 load;
    logic                 store;
    logic                 condbr;
    logic                 jal;
    logic                 jalr;
    logic                 imm20;
    logic                 imm12;
    logic                 rs1;     // rs1 is read
    logic                 rs2;     // rs2 is read
    logic                 rd;      // rd is written
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic [4:0]           shamt;
    logic [XLEN-1:0]      imm;
    logic                 imm_valid;
  } idu0_out_t;

  // RV32I decode table; unknown encodings come back with legal=0.
  function automatic idu0_out_t decode(input logic [INSTR_LEN-1:0] i,
                                       input logic [XLEN-1:0]      tag);
    idu0_out_t  p;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    p  = '0;
    p.instr     = i;
    p.instr_tag = tag;
    p.rs1_addr  = i[19:15];
    p.rs2_addr  = i[24:20];
    p.rd_addr   = i[11:7];
    p.shamt     = i[24:20];
    case (i[6:0])
      7'b0110111: begin p.legal = 1'b1; p.alu = 1'b1; p.imm20 = 1'b1; p.rd = 1'b1; end
      7'b0010111: begin p.legal = 1'b1; p.alu = 1'b1; p.pc = 1'b1; p.imm20 = 1'b1; p.rd = 1'b1; end
      7'b1101111: begin p.legal = 1'b1; p.jal = 1'b1; p.rd = 1'b1; end
      7'b1100111: begin
        p.legal = (f3 == 3'd0);
        p.jalr = 1'b1; p.imm12 = 1'b1; p.rs1 = 1'b1; p.rd = 1'b1;
      end
      7'b1100011: begin
        p.legal  = (f3 != 3'd2) && (f3 != 3'd3);
        p.condbr = 1'b1; p.rs1 = 1'b1; p.rs2 = 1'b1;
      end
      7'b0000011: begin
        p.legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        p.load  = 1'b1; p.rs1 = 1'b1; p.rd = 1'b1;
      end
      7'b0100011: begin
        p.legal = (f3 inside {3'd0, 3'd1, 3'd2});
        p.store = 1'b1; p.rs1 = 1'b1; p.rs2 = 1'b1;
      end
      7'b0010011: begin
        p.shift = (f3 == 3'd1) || (f3 == 3'd5);
        if (f3 == 3'd1)      p.legal = (f7 == 7'h00);
        else if (f3 == 3'd5) p.legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 p.legal = 1'b1;
        p.alu = 1'b1; p.imm12 = 1'b1; p.rs1 = 1'b1; p.rd = 1'b1;
      end
      7'b0110011: begin
        p.legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        p.alu   = 1'b1; p.shift = (f3 == 3'd1) || (f3 == 3'd5);
        p.rs1   = 1'b1; p.rs2 = 1'b1; p.rd = 1'b1;
      end
      default: p.legal = 1'b0;
    endcase
    p.imm = ({XLEN{p.imm20}}  & {i[31:12], 12'b0})
          | ({XLEN{p.imm12}}  & {{20{i[31]}}, i[31:20]})
          | ({XLEN{p.condbr}} & {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0})
          | ({XLEN{p.load}}   & {{20{i[31]}}, i[31:20]})
          | ({XLEN{p.store}}  & {{20{i[31]}}, i[31:25], i[11:7]})
          | ({XLEN{p.jal}}    & {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
    p.imm_valid = p.imm20 | p.imm12 | p.condbr | p.load | p.store | p.jal;
    return p;
  endfunction
endpackage

module idu_decq
  import idu_decq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_LEN-1:0] instr,
  input  logic                 instr_valid,
  input  logic [XLEN-1:0]      instr_tag,
  output logic                 instr_ready,
  input  logic                 flush,
  input  logic                 idu1_ready,
  output idu0_out_t            idu0_out,
  output logic                 idu0_out_valid,
  output logic [CNT_W-1:0]     q_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_LEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0]      mem_tag   [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;

  logic                 accept, fifo_wr, deq, out_ld, bypass;
  logic [INSTR_LEN-1:0] dec_instr;
  logic [XLEN-1:0]      dec_tag;
  idu0_out_t            dec_pkt;

  // Ready is a function of registered occupancy only, so idu1_ready never
  // reaches instr_ready combinationally.
  assign instr_ready = (q_count != CNT_W'(DEPTH));
  assign out_ld      = ~idu0_out_valid | idu1_ready;
  assign accept      = instr_valid & instr_ready & ~flush;
  assign fifo_wr     = accept & ~bypass;
  assign deq         = out_ld & (q_count != '0) & ~flush;
  assign dec_pkt     = decode(dec_instr, dec_tag);

  // Select the decode source: FIFO head, or the incoming word on a bypass load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bypass    = 1'b0;
    dec_instr = mem_instr[rd_ptr];
    dec_tag   = mem_tag[rd_ptr];
`ifdef IDU_DECQ_BYPASS_EN
    bypass = (q_count == '0) & out_ld & accept;
    if (bypass) begin
      dec_instr = instr;
      dec_tag   = instr_tag;
    end
`endif
  end

  // FIFO storage write.
  // NOTE: storage has no reset; q_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_instr[wr_ptr] <= instr;
      mem_tag[wr_ptr]   <= instr_tag;
    end
  end

  // Pointers and occupancy; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq)     rd_ptr <= rd_ptr + PTR_W'(1);
      q_count <= q_count + CNT_W'(fifo_wr) - CNT_W'(deq);
    end
  end

  // Output register: payload updates only on a load, valid tracks the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idu0_out       <= '0;
      idu0_out_valid <= 1'b0;
    end else if (flush) begin
      idu0_out_valid <= 1'b0;
    end else if (out_ld) begin
      idu0_out_valid <= deq | bypass;
      if (deq | bypass) idu0_out <= dec_pkt;
    end
  end
endmodule

// File: tb/tb_idu_decq.sv
// Directed self-checking bench for idu_decq in its default (no bypass) build,
// DEPTH=4. Inputs are driven 1 time unit after the rising edge and outputs are
// checked at the same point, away from the edge.

module tb_idu_decq;
  import idu_decq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst_n;
  logic [INSTR_LEN-1:0] instr;
  logic                 instr_valid;
  logic [XLEN-1:0]      instr_tag;
  logic                 instr_ready;
  logic                 flush;
  logic                 idu1_ready;
  idu0_out_t            idu0_out;
  logic                 idu0_out_valid;
  logic [CNT_W-1:0]     q_count;

  int n_checks = 0;
  int n_pass   = 0;

  idu_decq #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_tag      (instr_tag),
    .instr_ready    (instr_ready),
    .flush          (flush),
    .idu1_ready     (idu1_ready),
    .idu0_out       (idu0_out),
    .idu0_out_valid (idu0_out_valid),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tg);
    instr_valid = v;
    instr       = ins;
    instr_tag   = tg;
  endtask

  function automatic logic [31:0] mk_addi(input int rd, input int imm);
    logic [11:0] im;
    logic [4:0]  r;
    im = 12'(imm);
    r  = 5'(rd);
    return {im, 5'd0, 3'b000, r, 7'b0010011};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; idu1_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // ---- reset state ----
    #12;
    check("rst_valid", 64'(idu0_out_valid), 64'd0);
    check("rst_count", 64'(q_count), 64'd0);
    check("rst_pkt_zero", 64'(idu0_out == '0), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(instr_ready), 64'd1);

    // ---- single addi x1,x0,5 ----
    idu1_ready = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("single_q1", 64'(q_count), 64'd1);
    check("single_notyet", 64'(idu0_out_valid), 64'd0);
    tick();
    check("single_valid", 64'(idu0_out_valid), 64'd1);
    check("single_imm", 64'(idu0_out.imm), 64'd5);
    check("single_rd", 64'(idu0_out.rd_addr), 64'd1);
    check("single_tag", 64'(idu0_out.instr_tag), 64'h100);
    check("single_legal", 64'(idu0_out.legal), 64'd1);
    check("single_q0", 64'(q_count), 64'd0);
    tick();
    check("single_drained", 64'(idu0_out_valid), 64'd0);

    // ---- back-to-back stream of eight ----
    for (int c = 0; c < 10; c++) begin
      check("stream_ready", 64'(instr_ready), 64'd1);
      if (c >= 2) begin
        check("stream_valid", 64'(idu0_out_valid), 64'd1);
        check("stream_tag", 64'(idu0_out.instr_tag), 64'(4 * (c - 2)));
        check("stream_rd", 64'(idu0_out.rd_addr), 64'(c - 1));
      end
      if (c < 8) drive(1'b1, mk_addi(c + 1, c), 32'(4 * c));
      else       drive(1'b0, 32'h0, 32'h0);
      tick();
    end
    check("stream_end_valid", 64'(idu0_out_valid), 64'd0);
    check("stream_end_q", 64'(q_count), 64'd0);

    // ---- fill under backpressure, then drain with pointer wrap ----
    idu1_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, mk_addi(c + 1, 0), 32'(32'h200 + 4 * c));
      tick();
    end
    // A0 in the output register, A1..A4 in the FIFO, A5 still offered
    check("fill_q4", 64'(q_count), 64'd4);
    check("fill_ready0", 64'(instr_ready), 64'd0);
    check("fill_out_a0", 64'(idu0_out.instr_tag), 64'h200);
    idu1_ready = 1'b1;
    tick();
    check("drain_ready_back", 64'(instr_ready), 64'd1);
    check("drain_q3", 64'(q_count), 64'd3);
    check("drain_a1", 64'(idu0_out.instr_tag), 64'h204);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("drain_a2", 64'(idu0_out.instr_tag), 64'h208);
    check("drain_q3b", 64'(q_count), 64'd3);
    for (int k = 3; k < 6; k++) begin
      tick();
      check("drain_valid", 64'(idu0_out_valid), 64'd1);
      check("drain_order", 64'(idu0_out.instr_tag), 64'(32'h200 + 4 * k));
    end
    check("drain_empty", 64'(q_count), 64'd0);
    tick();
    check("drain_done", 64'(idu0_out_valid), 64'd0);

    // ---- flush mid-stream ----
    idu1_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, mk_addi(2, c), 32'(32'h300 + 4 * c));
      tick();
    end
    check("pre_flush_q3", 64'(q_count), 64'd3);
    check("pre_flush_valid", 64'(idu0_out_valid), 64'd1);
    flush = 1'b1;
    drive(1'b1, mk_addi(3, 7), 32'h3F0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_q0", 64'(q_count), 64'd0);
    check("flush_valid0", 64'(idu0_out_valid), 64'd0);
    check("flush_ready", 64'(instr_ready), 64'd1);
    check("flush_payload_held", 64'(idu0_out.instr_tag), 64'h300);
    idu1_ready = 1'b1;
    drive(1'b1, mk_addi(4, 9), 32'h400);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("post_flush_q1", 64'(q_count), 64'd1);
    check("post_flush_no_drop", 64'(idu0_out_valid), 64'd0);
    tick();
    check("post_flush_valid", 64'(idu0_out_valid), 64'd1);
    check("post_flush_tag", 64'(idu0_out.instr_tag), 64'h400);
    check("post_flush_imm", 64'(idu0_out.imm), 64'd9);
    tick();
    check("post_flush_idle", 64'(idu0_out_valid), 64'd0);

    // ---- jal / beq immediates and an illegal word ----
    drive(1'b1, 32'hFFDF_F0EF, 32'h500);
    tick();
    drive(1'b1, 32'h0000_0463, 32'h504);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'h508);
    check("jal_valid", 64'(idu0_out_valid), 64'd1);
    check("jal_imm", 64'(idu0_out.imm), 64'hFFFF_FFFC);
    check("jal_imm_valid", 64'(idu0_out.imm_valid), 64'd1);
    check("jal_rd", 64'(idu0_out.rd_addr), 64'd1);
    check("jal_flag", 64'(idu0_out.jal), 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("beq_imm", 64'(idu0_out.imm), 64'h8);
    check("beq_condbr", 64'(idu0_out.condbr), 64'd1);
    check("beq_tag", 64'(idu0_out.instr_tag), 64'h504);
    tick();
    check("illegal_valid", 64'(idu0_out_valid), 64'd1);
    check("illegal_legal0", 64'(idu0_out.legal), 64'd0);
    check("illegal_tag", 64'(idu0_out.instr_tag), 64'h508);
    tick();
    check("illegal_idle", 64'(idu0_out_valid), 64'd0);

    // ---- asynchronous reset with a full FIFO ----
    idu1_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, mk_addi(5, c), 32'(32'h600 + 4 * c));
      tick();
    end
    check("full_before_rst", 64'(q_count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(idu0_out_valid), 64'd0);
    check("async_rst_q", 64'(q_count), 64'd0);
    check("async_rst_pkt", 64'(idu0_out == '0), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("after_rst_ready", 64'(instr_ready), 64'd1);
    check("after_rst_valid", 64'(idu0_out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
